// File: rtl/channel_cfg_ctrl.sv
// channel_cfg_ctrl
//   Configuration controller for the multi-section PWL channel model
//   (section 0 = real pole, sections 1..N_SEC-1 = complex poles).
//   A host fills a shadow coefficient bank and requests a commit. The
//   active bank is swapped atomically only when the channel input has
//   been quiet for QUIET_CYC cycles and a symbol boundary is signalled.
//   Each swap pulses upd so the channel model re-evaluates its response.
//
//   Optional feature, macro CHCFG_TIMEOUT_EN: after TMO_CYC cycles in
//   ARMED without a natural swap the swap is forced and `forced` is set.
//   Without the macro ARMED waits indefinitely and `forced` is tied low.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   wr_en/wr_addr    shadow write; wr_addr = {section, field}
//   wr_data          coefficient value (field 0 pole_re, 1 pole_im, 2 gain)
//   commit           request shadow-to-active swap
//   act_in           one-cycle strobe per channel input PWL event
//   sym_strb         symbol-boundary strobe
//   pole_re/pole_im/gain  active bank
//   upd              one-cycle pulse in the cycle the active bank changes
//   busy             high in ARMED and HOLD
//   wr_err           one-cycle pulse on a rejected write
//   forced           last swap was forced by timeout
//   swap_cnt         completed swaps, wrapping
module channel_cfg_ctrl #(
  parameter int N_SEC     = 4,
  parameter int QUIET_CYC = 8,
  parameter int HOLD_CYC  = 4,
  parameter int TMO_CYC   = 1024
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [$clog2(N_SEC)+1:0] wr_addr,
  input  real                      wr_data,
  input  logic                     commit,
  input  logic                     act_in,
  input  logic                     sym_strb,
  output real                      pole_re [N_SEC],
  output real                      pole_im [N_SEC],
  output real                      gain    [N_SEC],
  output logic                     upd,
  output logic                     busy,
  output logic                     wr_err,
  output logic                     forced,
  output logic [15:0]              swap_cnt
);

  localparam int SW = $clog2(N_SEC);
  localparam int QW = $clog2(QUIET_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);

  // Elaboration-time parameter sanity
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("channel_cfg_ctrl: HOLD_CYC must be at least 1");
  end
  if (N_SEC < 2) begin : g_bad_nsec
    $error("channel_cfg_ctrl: N_SEC must be at least 2");
  end
  if (QUIET_CYC < 1) begin : g_bad_quiet
    $error("channel_cfg_ctrl: QUIET_CYC must be at least 1");
  end
  if (TMO_CYC < 1 || TMO_CYC > 65536) begin : g_bad_tmo
    $error("channel_cfg_ctrl: TMO_CYC must be in 1..65536");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_HOLD} state_t;

  state_t          state_reg, state_next;
  logic [QW-1:0]   quiet_cnt_reg;
  logic [HW-1:0]   hold_cnt_reg, hold_next;
  logic            pending_reg, pending_next;
  logic            quiet_full, swap_ok, do_swap;
  logic            wr_ok, sec_ok;
  logic [SW-1:0]   wr_sec;
  logic [1:0]      wr_fld;
  logic [N_SEC-1:0] wr_hit;

  real sh_re_reg [N_SEC];
  real sh_im_reg [N_SEC];
  real sh_g_reg  [N_SEC];

  assign wr_sec = wr_addr[SW+1:2];
  assign wr_fld = wr_addr[1:0];

  // Section range check only matters when N_SEC is not a power of two
  if (N_SEC == (1 << SW)) begin : g_sec_full
    assign sec_ok = 1'b1;
  end else begin : g_sec_part
    assign sec_ok = (int'(wr_sec) < N_SEC);
  end

  // Writes are frozen while ARMED so the bank being swapped is stable
  assign wr_ok = wr_en && (state_reg != ST_ARMED) && (wr_fld != 2'd3) && sec_ok;

  for (genvar gi = 0; gi < N_SEC; gi++) begin : g_hit
    assign wr_hit[gi] = wr_ok && (wr_sec == SW'(gi));
  end

  // Registered quiet_cnt is the count before this cycle's act_in, so an
  // act_in in the candidate cycle has to veto the swap explicitly.
  assign quiet_full = (quiet_cnt_reg == QW'(QUIET_CYC));
  assign swap_ok    = (state_reg == ST_ARMED) && quiet_full && sym_strb && !act_in;

`ifdef CHCFG_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg;
  logic        force_swap;
  logic        forced_reg;

  assign force_swap = (state_reg == ST_ARMED) && !swap_ok &&
                      (tmo_cnt_reg == 16'(TMO_CYC - 1));
  assign do_swap    = swap_ok || force_swap;
  assign forced     = forced_reg;
`else
  assign do_swap    = swap_ok;
  assign forced     = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_cnt_reg;
    pending_next = pending_reg;
    case (state_reg)
      ST_IDLE: begin
        if (commit) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (do_swap) begin
          state_next = ST_HOLD;
          hold_next  = HW'(HOLD_CYC);
        end
      end
      ST_HOLD: begin
        hold_next = hold_cnt_reg - HW'(1);
        if (hold_cnt_reg == HW'(1)) begin
          // A commit arriving in the last HOLD cycle still counts
          if (pending_reg || commit) begin
            state_next   = ST_ARMED;
            pending_next = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (commit) begin
          pending_next = 1'b1;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        hold_next    = '0;
        pending_next = 1'b0;
      end
    endcase
  end

  // Control state and status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      quiet_cnt_reg <= '0;
      hold_cnt_reg  <= '0;
      pending_reg   <= 1'b0;
      upd           <= 1'b0;
      busy          <= 1'b0;
      wr_err        <= 1'b0;
      swap_cnt      <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_next;
      pending_reg  <= pending_next;
      if (act_in)
        quiet_cnt_reg <= '0;
      else if (!quiet_full)
        quiet_cnt_reg <= quiet_cnt_reg + QW'(1);
      upd    <= do_swap;
      busy   <= (state_next != ST_IDLE);
      wr_err <= wr_en && !wr_ok;
      if (do_swap) swap_cnt <= swap_cnt + 16'd1;
    end
  end

  // Shadow and active coefficient banks
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_SEC; i++) begin
        sh_re_reg[i] <= 0.0;
        sh_im_reg[i] <= 0.0;
        sh_g_reg[i]  <= 0.0;
        pole_re[i]   <= 0.0;
        pole_im[i]   <= 0.0;
        gain[i]      <= 0.0;
      end
    end else begin
      for (int i = 0; i < N_SEC; i++) begin
        if (wr_hit[i]) begin
          case (wr_fld)
            2'd0:    sh_re_reg[i] <= wr_data;
            2'd1:    sh_im_reg[i] <= wr_data;
            default: sh_g_reg[i]  <= wr_data;
          endcase
        end
        if (do_swap) begin
          pole_re[i] <= sh_re_reg[i];
          pole_im[i] <= sh_im_reg[i];
          gain[i]    <= sh_g_reg[i];
        end
      end
    end
  end

`ifdef CHCFG_TIMEOUT_EN
  // Timeout counter and forced flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt_reg <= '0;
      forced_reg  <= 1'b0;
    end else begin
      if (state_reg != ST_ARMED && state_next == ST_ARMED)
        tmo_cnt_reg <= '0;
      else if (state_reg == ST_ARMED)
        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
      if (do_swap)
        forced_reg <= force_swap;
      else if (commit && state_reg != ST_ARMED)
        forced_reg <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_channel_cfg_ctrl.sv
// Testbench for channel_cfg_ctrl: randomized and directed stimulus checked
// against a timestamp-based reference model of the commit/swap rules.
module tb_channel_cfg_ctrl;
  localparam int N_SEC = 4;
  localparam int QUIET = 8;
  localparam int HOLD  = 4;
  localparam int TMO   = 16;
  localparam int AW    = $clog2(N_SEC) + 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  real           wr_data = 0.0;
  logic          commit = 1'b0;
  logic          act_in = 1'b0;
  logic          sym_strb = 1'b0;
  real           pole_re [N_SEC];
  real           pole_im [N_SEC];
  real           gain    [N_SEC];
  logic          upd, busy, wr_err, forced;
  logic [15:0]   swap_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  channel_cfg_ctrl #(
    .N_SEC(N_SEC), .QUIET_CYC(QUIET), .HOLD_CYC(HOLD), .TMO_CYC(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .act_in(act_in), .sym_strb(sym_strb),
    .pole_re(pole_re), .pole_im(pole_im), .gain(gain), .upd(upd),
    .busy(busy), .wr_err(wr_err), .forced(forced), .swap_cnt(swap_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: banks as [field][section]; modes tracked by cycle stamps
  real m_sh  [3][N_SEC];
  real m_act [3][N_SEC];
  int  cyc, last_act, hold_end, arm_start, m_swaps;
  bit  m_armed, m_pending, m_upd, m_busy, m_werr, m_forced;

  task automatic model_reset();
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < N_SEC; s++) begin
        m_sh[f][s]  = 0.0;
        m_act[f][s] = 0.0;
      end
    cyc = 0; last_act = -1; hold_end = -1; arm_start = 0; m_swaps = 0;
    m_armed = 0; m_pending = 0; m_upd = 0; m_busy = 0; m_werr = 0; m_forced = 0;
  endtask

  task automatic clr_in();
    wr_en = 0; wr_addr = '0; wr_data = 0.0; commit = 0; act_in = 0; sym_strb = 0;
  endtask

  task automatic set_wr(input int sec, input int fld, input real d);
    wr_en = 1; wr_addr = AW'((sec << 2) | fld); wr_data = d;
  endtask

  // Advance model and DUT by one clock; outputs are sampled 1 time unit later
  task automatic tick();
    int  q, fld, sec;
    bit  in_hold, in_idle, was_armed, nat, frc, wr_ok;
    q = cyc - (last_act + 1);
    if (q > QUIET) q = QUIET;
    in_hold   = (cyc <= hold_end);
    was_armed = m_armed;
    in_idle   = !was_armed && !in_hold;
    fld = int'(wr_addr[1:0]);
    sec = int'(wr_addr[AW-1:2]);
    nat = was_armed && (q == QUIET) && sym_strb && !act_in;
    frc = 0;
`ifdef CHCFG_TIMEOUT_EN
    frc = was_armed && !nat && (cyc - arm_start == TMO - 1);
`endif
    wr_ok  = wr_en && !was_armed && (fld != 3);
    m_werr = wr_en && !wr_ok;
    m_upd  = nat || frc;
    if (m_upd) begin
      for (int f = 0; f < 3; f++)
        for (int s = 0; s < N_SEC; s++) m_act[f][s] = m_sh[f][s];
      m_swaps++;
      m_forced = frc;
      m_armed  = 0;
      hold_end = cyc + HOLD;
    end
    if (wr_ok) m_sh[fld][sec] = wr_data;
    if (commit && in_idle) begin
      m_armed = 1; arm_start = cyc + 1; m_forced = 0;
    end
    if (commit && in_hold) begin
      m_pending = 1; m_forced = 0;
    end
    if (in_hold && cyc == hold_end && m_pending) begin
      m_armed = 1; arm_start = cyc + 1; m_pending = 0;
    end
    if (act_in) last_act = cyc;
    m_busy = m_armed || (cyc + 1 <= hold_end);
    @(posedge clk);
    #1;
    cyc++;
    if (m_upd)
      $display("[TB] swap %0d at cycle %0d forced=%0b swap_cnt=%0d", m_swaps, cyc, m_forced, swap_cnt);
  endtask

  task automatic do_reset();
    clr_in();
    rstn = 0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rstn = 1;
  endtask

  // Let any in-flight request finish (quiet input, symbol strobes present)
  task automatic wait_idle();
    clr_in();
    sym_strb = 1;
    for (int k = 0; k < 64 && (m_busy || busy); k++) tick();
    sym_strb = 0;
    n_tests++;
    if (m_busy || busy) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%0b still set after 64 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests += 5;
    if (upd !== 1'b0)    begin n_fail++; $display("FAIL reset_upd: got %0b want 0", upd); end
    if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    if (wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err: got %0b want 0", wr_err); end
    if (forced !== 1'b0) begin n_fail++; $display("FAIL reset_forced: got %0b want 0", forced); end
    if (swap_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_swap_cnt: got %0d want 0", swap_cnt); end
    for (int s = 0; s < N_SEC; s++) begin
      n_tests++;
      if (pole_re[s] != 0.0 || pole_im[s] != 0.0 || gain[s] != 0.0) begin
        n_fail++;
        $display("FAIL reset_bank[%0d]: got %g/%g/%g want 0/0/0", s, pole_re[s], pole_im[s], gain[s]);
      end
    end
  endtask

  task automatic test_load_commit();
    real vals [3];
    vals[0] = 4.153e9; vals[1] = 6.611e9; vals[2] = -0.98;
    for (int f = 0; f < 3; f++) begin
      set_wr(1, f, vals[f]);
      tick();
    end
    clr_in();
    commit = 1;
    tick();
    commit = 0;
    n_tests++;
    if (busy !== m_busy) begin n_fail++; $display("FAIL load_busy: got %0b want %0b", busy, m_busy); end
    while (cyc < 12) begin
      tick();
      n_tests++;
      if (upd !== m_upd) begin n_fail++; $display("FAIL load_early_upd cyc %0d: got %0b want %0b", cyc, upd, m_upd); end
    end
    sym_strb = 1;
    tick();
    sym_strb = 0;
    n_tests += 5;
    if (upd !== m_upd) begin n_fail++; $display("FAIL load_upd: got %0b want %0b", upd, m_upd); end
    if (pole_re[1] != vals[0]) begin n_fail++; $display("FAIL load_pole_re: got %g want %g", pole_re[1], vals[0]); end
    if (pole_im[1] != vals[1]) begin n_fail++; $display("FAIL load_pole_im: got %g want %g", pole_im[1], vals[1]); end
    if (gain[1] != vals[2])    begin n_fail++; $display("FAIL load_gain: got %g want %g", gain[1], vals[2]); end
    if (swap_cnt !== 16'(m_swaps)) begin n_fail++; $display("FAIL load_swap_cnt: got %0d want %0d", swap_cnt, m_swaps); end
    tick();
    n_tests++;
    if (upd !== 1'b0) begin n_fail++; $display("FAIL load_upd_pulse: got %0b want 0", upd); end
  endtask

  task automatic test_quiet_window();
    int start;
    wait_idle();
    set_wr(2, 0, -1.5e9);
    commit = 1;
    tick();
    clr_in();
    start = m_swaps;
    for (int k = 0; k < 40; k++) begin
      act_in   = (k % 5 == 0);
      sym_strb = (k % 4 == 0);
      tick();
      n_tests++;
      if (upd !== m_upd) begin n_fail++; $display("FAIL quiet_blocked_upd k=%0d: got %0b want %0b", k, upd, m_upd); end
    end
    act_in = 0;
    for (int k = 0; k < 40 && m_swaps == start; k++) begin
      sym_strb = (k % 4 == 0);
      tick();
      n_tests++;
      if (upd !== m_upd) begin n_fail++; $display("FAIL quiet_release_upd k=%0d: got %0b want %0b", k, upd, m_upd); end
    end
    clr_in();
    n_tests += 2;
    if (m_swaps == start) begin n_fail++; $display("FAIL quiet_timeout: swap_cnt=%0d, required a swap", swap_cnt); end
    if (pole_re[2] != m_act[0][2]) begin n_fail++; $display("FAIL quiet_pole_re: got %g want %g", pole_re[2], m_act[0][2]); end
  endtask

  task automatic test_illegal_writes();
    wait_idle();
    set_wr(2, 3, 123.0);
    tick();
    clr_in();
    n_tests++;
    if (wr_err !== m_werr) begin n_fail++; $display("FAIL illegal_field3: wr_err=%0b want %0b", wr_err, m_werr); end
    tick();
    n_tests++;
    if (wr_err !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse: wr_err=%0b want 0", wr_err); end
    commit = 1; act_in = 1;
    tick();
    commit = 0;
    set_wr(2, 0, 7.5);
    tick();
    clr_in();
    n_tests += 2;
    if (wr_err !== m_werr) begin n_fail++; $display("FAIL illegal_armed: wr_err=%0b want %0b", wr_err, m_werr); end
    if (busy !== m_busy)   begin n_fail++; $display("FAIL illegal_busy: got %0b want %0b", busy, m_busy); end
    sym_strb = 1;
    for (int k = 0; k < 30 && m_armed; k++) begin
      tick();
      n_tests++;
      if (upd !== m_upd) begin n_fail++; $display("FAIL illegal_upd k=%0d: got %0b want %0b", k, upd, m_upd); end
    end
    clr_in();
    for (int s = 0; s < N_SEC; s++) begin
      n_tests++;
      if (pole_re[s] != m_act[0][s] || pole_im[s] != m_act[1][s] || gain[s] != m_act[2][s]) begin
        n_fail++;
        $display("FAIL illegal_bank[%0d]: got %g/%g/%g want %g/%g/%g", s, pole_re[s], pole_im[s],
                 gain[s], m_act[0][s], m_act[1][s], m_act[2][s]);
      end
    end
  endtask

  task automatic test_hold_pending();
    int base;
    wait_idle();
    base = m_swaps;
    set_wr(3, 2, 2.5);
    commit = 1;
    tick();
    clr_in();
    sym_strb = 1;
    for (int k = 0; k < 20 && !m_upd; k++) tick();
    sym_strb = 0;
    n_tests++;
    if (upd !== m_upd) begin n_fail++; $display("FAIL hold_first_upd: got %0b want %0b", upd, m_upd); end
    tick();
    commit = 1;
    set_wr(3, 0, 9.25);
    tick();
    clr_in();
    for (int k = 0; k < HOLD + 2; k++) begin
      tick();
      n_tests++;
      if (busy !== m_busy) begin n_fail++; $display("FAIL hold_busy k=%0d: got %0b want %0b", k, busy, m_busy); end
    end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_rearmed: busy=%0b want 1", busy); end
    sym_strb = 1;
    for (int k = 0; k < 20 && m_swaps < base + 2; k++) tick();
    clr_in();
    n_tests += 3;
    if (swap_cnt !== 16'(base + 2)) begin n_fail++; $display("FAIL hold_swap_cnt: got %0d want %0d", swap_cnt, base + 2); end
    if (pole_re[3] != 9.25) begin n_fail++; $display("FAIL hold_write: pole_re[3]=%g want 9.25", pole_re[3]); end
    if (gain[3] != 2.5)     begin n_fail++; $display("FAIL hold_gain: gain[3]=%g want 2.5", gain[3]); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = AW'($urandom);
      wr_data  = real'($urandom_range(0, 1000000)) * 0.001 - 500.0;
      commit   = ($urandom_range(0, 9) == 0);
      act_in   = ($urandom_range(0, 15) == 0);
      sym_strb = ($urandom_range(0, 2) == 0);
      tick();
      n_tests++;
      if (upd !== m_upd || busy !== m_busy || wr_err !== m_werr || forced !== m_forced ||
          swap_cnt !== 16'(m_swaps)) begin
        n_fail++;
        $display("FAIL rand_ctrl k=%0d: upd/busy/wr_err/forced/cnt=%0b%0b%0b%0b/%0d want %0b%0b%0b%0b/%0d",
                 k, upd, busy, wr_err, forced, swap_cnt, m_upd, m_busy, m_werr, m_forced, m_swaps);
      end
      if (m_upd) begin
        for (int s = 0; s < N_SEC; s++) begin
          n_tests++;
          if (pole_re[s] != m_act[0][s] || pole_im[s] != m_act[1][s] || gain[s] != m_act[2][s]) begin
            n_fail++;
            $display("FAIL rand_bank[%0d] k=%0d: got %g/%g/%g want %g/%g/%g", s, k, pole_re[s],
                     pole_im[s], gain[s], m_act[0][s], m_act[1][s], m_act[2][s]);
          end
        end
      end
    end
    clr_in();
  endtask

`ifdef CHCFG_TIMEOUT_EN
  task automatic test_timeout();
    int at;
    wait_idle();
    commit = 1; act_in = 1;
    tick();
    commit = 0; sym_strb = 1;
    at = -1;
    for (int k = 0; k < 30 && at < 0; k++) begin
      tick();
      n_tests++;
      if (upd !== m_upd) begin n_fail++; $display("FAIL tmo_upd k=%0d: got %0b want %0b", k, upd, m_upd); end
      if (upd === 1'b1) at = k;
    end
    n_tests += 2;
    if (at != TMO - 1) begin n_fail++; $display("FAIL tmo_latency: swap after %0d ARMED cycles, want %0d", at + 1, TMO); end
    if (forced !== 1'b1) begin n_fail++; $display("FAIL tmo_forced: got %0b want 1", forced); end
    wait_idle();
    commit = 1;
    tick();
    sym_strb = 1; commit = 0;
    for (int k = 0; k < 20 && m_armed; k++) tick();
    clr_in();
    n_tests++;
    if (forced !== 1'b0) begin n_fail++; $display("FAIL tmo_natural_clears: forced=%0b want 0", forced); end
  endtask
`endif

  task automatic test_reset_mid_armed();
    wait_idle();
    set_wr(1, 0, 1.0e3);
    tick();
    clr_in();
    commit = 1; act_in = 1;
    tick();
    commit = 0;
    tick();
    tick();
    #2 rstn = 0;
    #1;
    n_tests += 4;
    if (pole_re[1] != 0.0)  begin n_fail++; $display("FAIL rst_async_bank: pole_re[1]=%g want 0", pole_re[1]); end
    if (swap_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_async_cnt: got %0d want 0", swap_cnt); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_async_busy: got %0b want 0", busy); end
    if (upd !== 1'b0)       begin n_fail++; $display("FAIL rst_async_upd: got %0b want 0", upd); end
    do_reset();
    sym_strb = 1;
    for (int k = 0; k < QUIET + 4; k++) begin
      tick();
      n_tests++;
      if (upd !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_release k=%0d: upd=%0b busy=%0b want 0 0", k, upd, busy);
      end
    end
    commit = 1;
    tick();
    commit = 0;
    for (int k = 0; k < 20 && m_armed; k++) tick();
    clr_in();
    n_tests += 2;
    if (swap_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_after_swap_cnt: got %0d want 1", swap_cnt); end
    if (pole_re[1] != 0.0)  begin n_fail++; $display("FAIL rst_shadow_discarded: pole_re[1]=%g want 0", pole_re[1]); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_commit();
    test_quiet_window();
    test_illegal_writes();
    test_hold_pending();
    test_random();
`ifdef CHCFG_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_armed();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound in case a stimulus loop stalls
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
